// File: rtl/s_ram_bist.sv
// ============================================================================
// Module   : s_ram_bist
// Brief    : March-test BIST initiator for the s_ram single-port synchronous RAM
// Revision : 1.0
// ============================================================================
`default_nettype none

module s_ram_bist #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    ADDR_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] PATTERN    = 8'h55
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [DATA_WIDTH-1:0] fail_data,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

  typedef enum logic [3:0] {
    IDLE, M0_W, M1_RD, M1_CW, M2_RD, M2_CW, M3_RD, M3_C, DONE, FAIL
  } state_t;

  state_t                  state, state_n;
  logic [ADDR_WIDTH-1:0]   addr, addr_n;
  logic                    check;
  logic [DATA_WIDTH-1:0]   expect_data;
  logic                    mismatch;
  logic                    last_match;

  // Read data for the address issued in a *_RD state is compared in the
  // following *_CW / M3_C state.
  assign check       = (state == M1_CW) || (state == M2_CW) || (state == M3_C);
  assign expect_data = (state == M2_CW) ? ~PATTERN : PATTERN;
  assign mismatch    = check && (mem_rdata != expect_data);
  assign last_match  = (state == M3_C) && !mismatch && (addr == LAST_ADDR);

  assign busy     = !((state == IDLE) || (state == DONE) || (state == FAIL));
  assign mem_addr = busy ? addr : '0;

  always_comb begin
    state_n   = state;
    addr_n    = addr;
    mem_we    = 1'b0;
    mem_wdata = '0;
    case (state)
      IDLE, DONE, FAIL: begin
        if (start) begin
          state_n = M0_W;
          addr_n  = '0;
        end
      end
      M0_W: begin
        mem_we    = 1'b1;
        mem_wdata = PATTERN;
        if (addr == LAST_ADDR) begin
          state_n = M1_RD;
          addr_n  = '0;
        end else begin
          addr_n = addr + ADDR_ONE;
        end
      end
      M1_RD: state_n = M1_CW;
      M1_CW: begin
        mem_we    = 1'b1;
        mem_wdata = ~PATTERN;
        if (mismatch)                state_n = FAIL;
        else if (addr == LAST_ADDR)  state_n = M2_RD;
        else begin
          state_n = M1_RD;
          addr_n  = addr + ADDR_ONE;
        end
      end
      M2_RD: state_n = M2_CW;
      M2_CW: begin
        mem_we    = 1'b1;
        mem_wdata = PATTERN;
        if (mismatch)          state_n = FAIL;
        else if (addr == '0)   state_n = M3_RD;
        else begin
          state_n = M2_RD;
          addr_n  = addr - ADDR_ONE;
        end
      end
      M3_RD: state_n = M3_C;
      M3_C: begin
        if (mismatch)                state_n = FAIL;
        else if (addr == LAST_ADDR)  state_n = DONE;
        else begin
          state_n = M3_RD;
          addr_n  = addr + ADDR_ONE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      addr      <= '0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_addr <= '0;
      fail_data <= '0;
    end else begin
      state <= state_n;
      addr  <= addr_n;
      if (!busy && start) begin
        done      <= 1'b0;
        pass      <= 1'b0;
        fail_addr <= '0;
        fail_data <= '0;
      end
      if (last_match) begin
        done <= 1'b1;
        pass <= 1'b1;
      end
      // Only the first mismatch is captured: the FSM leaves the march on it.
      if (mismatch) begin
        done      <= 1'b1;
        pass      <= 1'b0;
        fail_addr <= addr;
        fail_data <= mem_rdata;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_s_ram_bist.sv
// ============================================================================
// Module   : tb_s_ram_bist
// Brief    : Scoreboard bench for s_ram_bist with a fault-injectable RAM model
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_s_ram_bist;

  localparam int AW = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          busy, done, pass, mem_we;
  logic [AW-1:0] fail_addr, mem_addr;
  logic [DW-1:0] fail_data, mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  s_ram_bist #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PATTERN(8'h55)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .pass(pass), .fail_addr(fail_addr), .fail_data(fail_data),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // RAM model; fault: 0 good, 1 addr9 bit0 stuck-1, 2 addr3 stuck 8'h55, 3 F aliases 0
  int            fault = 0;
  logic [DW-1:0] mem [16];

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
      if (fault == 3 && mem_addr == 4'hF) mem[0] <= mem_wdata;
    end
    if (fault == 1 && mem_addr == 4'h9)      mem_rdata <= mem[mem_addr] | 8'h01;
    else if (fault == 2 && mem_addr == 4'h3) mem_rdata <= 8'h55;
    else                                     mem_rdata <= mem[mem_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string         name;
    bit            pass_e;
    logic [AW-1:0] fa;
    logic [DW-1:0] fd;
    int            len;
    int            start_cyc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: each rising edge of done retires one scoreboard entry.
  logic done_q = 1'b0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done && !done_q) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk({e.name, "_pass"}, 32'(pass), 32'(e.pass_e));
          chk({e.name, "_fail_addr"}, 32'(fail_addr), 32'(e.fa));
          chk({e.name, "_fail_data"}, 32'(fail_data), 32'(e.fd));
          chk({e.name, "_cycles"}, 32'(cyc - e.start_cyc), 32'(e.len));
        end
      end
      done_q = done;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst   = 1'b1;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Pulse start for one cycle; optionally record the expected run outcome.
  task automatic issue(input string nm, input bit push, input bit p,
                       input logic [AW-1:0] fa, input logic [DW-1:0] fd, input int len);
    exp_t e;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (push) begin
      e.name = nm; e.pass_e = p; e.fa = fa; e.fd = fd; e.len = len; e.start_cyc = cyc;
      sb.push_back(e);
    end
  endtask

  task automatic wait_done(input string nm, input int limit);
    int k = 0;
    while (!done && k < limit) begin
      @(negedge clk);
      k++;
    end
    chk({nm, "_done_seen"}, 32'(done), 32'd1);
  endtask

  initial begin
    int we_cnt;
    bit all55;

    do_reset();
    @(negedge clk);
    chk("reset_status", {busy, done, pass, fail_addr, fail_data}, '0);
    chk("reset_mem_port", {mem_we, mem_addr, mem_wdata}, '0);

    // 1. good RAM
    fault = 0;
    issue("good", 1'b1, 1'b1, 4'h0, 8'h00, 112);
    @(negedge clk);
    chk("good_busy", 32'(busy), 32'd1);
    wait_done("good", 200);
    all55 = 1'b1;
    for (int i = 0; i < 16; i++) if (mem[i] !== 8'h55) all55 = 1'b0;
    chk("good_final_ram", 32'(all55), 32'd1);

    // 2. bit0 of addr 9 stuck-1: invisible under 8'h55, caught reading ~P in M2
    do_reset();
    fault = 1;
    issue("stuck_bit", 1'b1, 1'b0, 4'h9, 8'hAB, 62);
    wait_done("stuck_bit", 200);

    // 3. addr 3 stuck at 8'h55
    do_reset();
    fault = 2;
    issue("stuck_word", 1'b1, 1'b0, 4'h3, 8'h55, 74);
    wait_done("stuck_word", 200);
    we_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mem_we) we_cnt++;
    end
    chk("stuck_word_no_access", 32'(we_cnt), 32'd0);
    chk("stuck_word_idle", {busy, done}, 32'b01);

    // 4. F aliases onto 0: the M2 write to F corrupts 0
    do_reset();
    fault = 3;
    issue("alias", 1'b1, 1'b0, 4'h0, 8'h55, 80);
    wait_done("alias", 200);

    // 5. rst in cycle 40, then a clean rerun
    do_reset();
    fault = 0;
    issue("abort", 1'b0, 1'b0, 4'h0, 8'h00, 0);
    repeat (39) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_status", {busy, done, mem_we, mem_addr}, '0);
    issue("rerun", 1'b1, 1'b1, 4'h0, 8'h00, 112);
    wait_done("rerun", 200);

    // 6. start ignored while busy; start in DONE restarts
    do_reset();
    issue("busy_start", 1'b1, 1'b1, 4'h0, 8'h00, 112);
    repeat (30) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("busy_start", 200);
    @(negedge clk);
    issue("restart", 1'b1, 1'b1, 4'h0, 8'h00, 112);
    chk("restart_clears_done", {busy, done}, 32'b10);
    wait_done("restart", 200);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
